// File: rtl/wt_dcache_line_reader.sv
// -----------------------------------------------------------------------------
// wt_dcache_line_reader
//
// Reads one complete cache line through a single cache-memory read port.
// A request (index plus physical tag) is accepted in IDLE. The block then
// issues one 64-bit word read per line offset. For every response it checks
// that the word hit, and that it hit in the same way as word 0. When the walk
// ends, it returns the assembled line together with the hit status and the
// one-hot way.
//
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_i / req_ready_o   line request handshake (ready only in IDLE)
//   req_idx_i, req_tag_i  line index and tag to compare
//   rd_*_o                word read request towards the cache memory
//   rd_ack_i              grant for rd_req_o in the current cycle
//   rd_hit_oh_i, rd_data_i  response, valid the cycle after a grant
//   line_vld_o / line_ready_i  result handshake
//   line_hit_o, line_way_o, line_data_o  result; way and data are zero on a miss
// -----------------------------------------------------------------------------
module wt_dcache_line_reader #(
    parameter int unsigned LineWidth = 128,
    parameter int unsigned TagWidth  = 44,
    parameter int unsigned IdxWidth  = 8,
    parameter int unsigned SetAssoc  = 8,
    parameter logic        HighPrio  = 1'b0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             req_i,
    output logic                             req_ready_o,
    input  logic [IdxWidth-1:0]              req_idx_i,
    input  logic [TagWidth-1:0]              req_tag_i,
    output logic                             rd_req_o,
    input  logic                             rd_ack_i,
    output logic [IdxWidth-1:0]              rd_idx_o,
    output logic [$clog2(LineWidth/8)-1:0]   rd_off_o,
    output logic                             rd_tag_only_o,
    output logic                             rd_prio_o,
    output logic [TagWidth-1:0]              rd_tag_o,
    input  logic [SetAssoc-1:0]              rd_hit_oh_i,
    input  logic [63:0]                      rd_data_i,
    output logic                             line_vld_o,
    input  logic                             line_ready_i,
    output logic                             line_hit_o,
    output logic [SetAssoc-1:0]              line_way_o,
    output logic [LineWidth-1:0]             line_data_o
);

    localparam int unsigned W    = LineWidth / 64;
    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [IdxWidth-1:0]     idx_q;
    logic [TagWidth-1:0]     tag_q;
    logic [CntW-1:0]         word_cnt_q;
    logic [CntW-1:0]         pend_off_q;
    logic                    pend_q;
    logic                    issue_done_q;
    logic                    miss_q;
    logic [SetAssoc-1:0]     way_q;
    logic [W-1:0][63:0]      buf_q;
    logic                    line_hit_q;
    logic [SetAssoc-1:0]     line_way_q;
    logic [LineWidth-1:0]    line_data_q;

    logic                    grant_s;
    logic                    last_grant_s;
    logic                    resp_s;
    logic                    miss_d;
    logic                    issue_done_d;
    logic                    pend_d;
    logic [SetAssoc-1:0]     way_d;
    logic [W-1:0][63:0]      buf_d;

    // The read request is a pure function of registered state, so there is no
    // combinational path from the grant or the hit vector back to it.
    assign rd_req_o      = (state_q == READ) && !issue_done_q && !miss_q;
    assign req_ready_o   = (state_q == IDLE);
    assign line_vld_o    = (state_q == DONE);
    assign rd_idx_o      = idx_q;
    assign rd_tag_o      = tag_q;
    assign rd_off_o      = {word_cnt_q, 3'b000};
    assign rd_tag_only_o = 1'b0;
    assign rd_prio_o     = HighPrio;
    assign line_hit_o    = line_hit_q;
    assign line_way_o    = line_way_q;
    assign line_data_o   = line_data_q;

    // Grant bookkeeping and response evaluation (way check and word capture).
    always_comb begin
        grant_s      = rd_req_o && rd_ack_i;
        last_grant_s = grant_s && (word_cnt_q == CntW'(W - 1));
        resp_s       = pend_q && ((state_q == READ) || (state_q == DRAIN));
        issue_done_d = issue_done_q || last_grant_s;
        pend_d       = grant_s;
        miss_d       = miss_q;
        way_d        = way_q;
        buf_d        = buf_q;
        if (resp_s) begin
            if (pend_off_q == '0) begin
                // Word 0 selects the way that every later word must match.
                if (rd_hit_oh_i == '0) begin
                    miss_d = 1'b1;
                end else begin
                    way_d = rd_hit_oh_i;
                end
            end else begin
                if (rd_hit_oh_i != way_q) begin
                    miss_d = 1'b1;
                end else begin
                    miss_d = miss_q;
                end
            end
            // A response that arrives after a miss has been seen is dropped.
            if (!miss_d) begin
                buf_d[pend_off_q] = rd_data_i;
            end else begin
                buf_d = buf_q;
            end
        end else begin
            miss_d = miss_q;
        end
    end

    // Line-reader state machine with the registered result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            tag_q        <= '0;
            word_cnt_q   <= '0;
            pend_off_q   <= '0;
            pend_q       <= 1'b0;
            issue_done_q <= 1'b0;
            miss_q       <= 1'b0;
            way_q        <= '0;
            buf_q        <= '0;
            line_hit_q   <= 1'b0;
            line_way_q   <= '0;
            line_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        idx_q        <= req_idx_i;
                        tag_q        <= req_tag_i;
                        word_cnt_q   <= '0;
                        pend_q       <= 1'b0;
                        issue_done_q <= 1'b0;
                        miss_q       <= 1'b0;
                        way_q        <= '0;
                        buf_q        <= '0;
                        state_q      <= READ;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                READ: begin
                    miss_q       <= miss_d;
                    way_q        <= way_d;
                    buf_q        <= buf_d;
                    issue_done_q <= issue_done_d;
                    pend_q       <= pend_d;
                    if (grant_s) begin
                        pend_off_q <= word_cnt_q;
                        // The counter parks on the last word instead of wrapping.
                        if (!last_grant_s) begin
                            word_cnt_q <= word_cnt_q + CntW'(1);
                        end else begin
                            word_cnt_q <= word_cnt_q;
                        end
                    end else begin
                        pend_off_q <= pend_off_q;
                    end
                    if (issue_done_d || miss_d) begin
                        if (pend_d) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q     <= DONE;
                            line_hit_q  <= !miss_d;
                            line_way_q  <= miss_d ? '0 : way_d;
                            line_data_q <= miss_d ? '0 : LineWidth'(buf_d);
                        end
                    end else begin
                        state_q <= READ;
                    end
                end
                DRAIN: begin
                    miss_q      <= miss_d;
                    way_q       <= way_d;
                    buf_q       <= buf_d;
                    pend_q      <= 1'b0;
                    state_q     <= DONE;
                    line_hit_q  <= !miss_d;
                    line_way_q  <= miss_d ? '0 : way_d;
                    line_data_q <= miss_d ? '0 : LineWidth'(buf_d);
                end
                DONE: begin
                    if (line_ready_i) begin
                        state_q     <= IDLE;
                        line_hit_q  <= 1'b0;
                        line_way_q  <= '0;
                        line_data_q <= '0;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wt_dcache_line_reader.sv
module tb_wt_dcache_line_reader;
    localparam int LW = 128;
    localparam int TW = 8;
    localparam int IW = 6;
    localparam int SA = 4;
    localparam int W  = LW / 64;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            req_i = 1'b0;
    logic            req_ready_o;
    logic [IW-1:0]   req_idx_i = '0;
    logic [TW-1:0]   req_tag_i = '0;
    logic            rd_req_o;
    logic            rd_ack_i = 1'b0;
    logic [IW-1:0]   rd_idx_o;
    logic [3:0]      rd_off_o;
    logic            rd_tag_only_o;
    logic            rd_prio_o;
    logic [TW-1:0]   rd_tag_o;
    logic [SA-1:0]   rd_hit_oh_i = '0;
    logic [63:0]     rd_data_i = '0;
    logic            line_vld_o;
    logic            line_ready_i = 1'b0;
    logic            line_hit_o;
    logic [SA-1:0]   line_way_o;
    logic [LW-1:0]   line_data_o;

    int tests = 0;
    int fails = 0;

    // Per-word plan of what the cache memory returns for the current line.
    logic [SA-1:0] plan_hit  [W];
    logic [63:0]   plan_data [W];

    wt_dcache_line_reader #(
        .LineWidth(LW), .TagWidth(TW), .IdxWidth(IW), .SetAssoc(SA), .HighPrio(1'b0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .req_ready_o(req_ready_o),
        .req_idx_i(req_idx_i), .req_tag_i(req_tag_i), .rd_req_o(rd_req_o),
        .rd_ack_i(rd_ack_i), .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o),
        .rd_tag_only_o(rd_tag_only_o), .rd_prio_o(rd_prio_o), .rd_tag_o(rd_tag_o),
        .rd_hit_oh_i(rd_hit_oh_i), .rd_data_i(rd_data_i), .line_vld_o(line_vld_o),
        .line_ready_i(line_ready_i), .line_hit_o(line_hit_o), .line_way_o(line_way_o),
        .line_data_o(line_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_line_vld", line_vld_o, 0);
        chk("rst_line_hit", line_hit_o, 0);
        chk("rst_line_way", line_way_o, 0);
        chk("rst_line_data", line_data_o, 0);
        chk("rst_rd_idx", rd_idx_o, 0);
        chk("rst_rd_off", rd_off_o, 0);
        chk("rst_rd_tag", rd_tag_o, 0);
    endtask

    // Drives one full line read, playing the cache memory from the plan and
    // checking the result against what the plan implies.
    task automatic run_line(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                            input int deny_w1, input bit rand_ack, input int ready_delay);
        logic          exp_hit;
        logic [SA-1:0] exp_way;
        logic [LW-1:0] exp_data;
        int first_bad, nxt, rw, denials, denied_w1, cyc;
        bit pend, done, ack;

        // Reference: the line hits only if every word hits the same nonzero way.
        exp_hit   = (plan_hit[0] != '0);
        first_bad = (plan_hit[0] == '0) ? 0 : W;
        for (int k = 1; k < W; k++) begin
            if (plan_hit[k] != plan_hit[0]) begin
                exp_hit = 1'b0;
                if (first_bad == W) first_bad = k;
            end
        end
        exp_way  = exp_hit ? plan_hit[0] : '0;
        exp_data = '0;
        for (int k = 0; k < W; k++) exp_data[64*k +: 64] = plan_data[k];
        if (!exp_hit) exp_data = '0;

        chk("req_ready_idle", req_ready_o, 1);
        req_i = 1'b1; req_idx_i = idx; req_tag_i = tag;
        @(negedge clk_i);
        req_i = 1'b0;
        cyc = 1; nxt = 0; rw = 0; denials = 0; denied_w1 = 0; pend = 0; done = 0;
        while (!done && cyc < 100) begin
            if (pend) begin
                rd_hit_oh_i = plan_hit[rw];
                rd_data_i   = plan_data[rw];
                chk("rd_tag", rd_tag_o, tag);
            end else begin
                rd_hit_oh_i = SA'($urandom);
                rd_data_i   = {$urandom, $urandom};
            end
            pend = 0;
            if (line_vld_o) begin
                done = 1;
                rd_ack_i = 1'b0;
            end else begin
                if (rd_req_o) begin
                    chk("rd_off", rd_off_o, nxt * 8);
                    chk("rd_idx", rd_idx_o, idx);
                    if (nxt == 1 && denied_w1 < deny_w1) begin
                        ack = 0; denied_w1++;
                    end else if (rand_ack) begin
                        ack = ($urandom_range(0, 1) == 1);
                    end else begin
                        ack = 1;
                    end
                    rd_ack_i = ack;
                    if (ack) begin
                        pend = 1; rw = nxt % W; nxt++;
                    end else begin
                        denials++;
                    end
                end else begin
                    rd_ack_i = 1'($urandom);
                end
                @(negedge clk_i);
                cyc++;
            end
        end
        rd_ack_i = 1'b0;
        chk("line_vld_timeout", done, 1);
        if (exp_hit) begin
            chk("latency", cyc, 2 + W + denials);
        end else begin
            chk("grants_after_miss", (nxt <= first_bad + 2) && (nxt >= first_bad + 1), 1);
        end
        chk("line_hit", line_hit_o, exp_hit);
        chk("line_way", line_way_o, exp_way);
        chk("line_data", line_data_o, exp_data);
        chk("ready_vs_vld", req_ready_o, 0);
        for (int i = 0; i < ready_delay; i++) begin
            req_i = 1'($urandom);
            req_idx_i = IW'($urandom);
            @(negedge clk_i);
            chk("hold_vld", line_vld_o, 1);
            chk("hold_ready", req_ready_o, 0);
            chk("hold_hit", line_hit_o, exp_hit);
            chk("hold_way", line_way_o, exp_way);
            chk("hold_data", line_data_o, exp_data);
            chk("hold_rd_req", rd_req_o, 0);
        end
        req_i = 1'b0;
        line_ready_i = 1'b1;
        @(negedge clk_i);
        line_ready_i = 1'b0;
        chk("post_hs_vld", line_vld_o, 0);
        chk("post_hs_ready", req_ready_o, 1);
    endtask

    initial begin
        logic [SA-1:0] way;
        // Reset state
        #12;
        chk_reset_outputs();
        chk("tag_only", rd_tag_only_o, 0);
        chk("prio", rd_prio_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1: clean hit in way 2, grants every cycle
        plan_hit[0] = 4'b0100; plan_hit[1] = 4'b0100;
        plan_data[0] = 64'hAAAA_AAAA_AAAA_AAAA; plan_data[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        run_line(6'h15, 8'h3C, 0, 1'b0, 0);
        // 2: word 1 denied three times
        run_line(6'h15, 8'h3C, 3, 1'b0, 0);
        // 3: word 0 misses while word 1 is granted
        plan_hit[0] = 4'b0000; plan_hit[1] = 4'b0100;
        run_line(6'h2A, 8'h11, 0, 1'b0, 0);
        // 4: words hit different ways
        plan_hit[0] = 4'b0010; plan_hit[1] = 4'b1000;
        run_line(6'h07, 8'hE1, 0, 1'b0, 0);
        // 5: consumer stalls five cycles in DONE
        plan_hit[0] = 4'b0001; plan_hit[1] = 4'b0001;
        plan_data[0] = 64'h0123_4567_89AB_CDEF; plan_data[1] = 64'hFEDC_BA98_7654_3210;
        run_line(6'h3F, 8'hFF, 0, 1'b0, 5);
        run_line(6'h01, 8'h02, 0, 1'b0, 0);

        // 6: reset while a response is outstanding
        req_i = 1'b1; req_idx_i = 6'h1B; req_tag_i = 8'h5A;
        @(negedge clk_i);
        req_i = 1'b0; rd_ack_i = 1'b1;
        @(negedge clk_i);
        rd_ack_i = 1'b0;
        rd_hit_oh_i = 4'b0100; rd_data_i = 64'h1111_2222_3333_4444;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        plan_hit[0] = 4'b1000; plan_hit[1] = 4'b1000;
        plan_data[0] = 64'hCAFE_0000_0000_0001; plan_data[1] = 64'hCAFE_0000_0000_0002;
        run_line(6'h1B, 8'h5A, 0, 1'b0, 0);

        // Randomized lines with random grants, misses and consumer stalls
        for (int n = 0; n < 30; n++) begin
            way = SA'(1 << $urandom_range(0, SA - 1));
            for (int k = 0; k < W; k++) begin
                plan_hit[k]  = ($urandom_range(0, 4) == 0) ? SA'($urandom) : way;
                plan_data[k] = {$urandom, $urandom};
            end
            run_line(IW'($urandom), TW'($urandom), 0, 1'b1, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
